// File: rtl/popcount_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : popcount_pkg
//  Purpose : Shared types and helpers for the sequential population counter.
//            - state_t : FSM encoding (IDLE / COUNT / DONE), 2-bit
//            - cnt_w   : bits needed to hold a count in the range 0..n
//  Revision: 1.0 - initial release
// ============================================================================
package popcount_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/chunk_popcount.sv
`default_nettype none
// ============================================================================
//  Module  : chunk_popcount
//  Purpose : Combinational ones counter for one CHUNK-bit slice.
//  Ports   : i_bits  [CHUNK-1:0]          bits to count
//            o_count [cnt_w(CHUNK)-1:0]   number of ones, 0..CHUNK
//  Revision: 1.0 - initial release
// ============================================================================
module chunk_popcount
  import popcount_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0]          i_bits,
  output logic [cnt_w(CHUNK)-1:0]   o_count
);

  localparam int CCW = cnt_w(CHUNK);

  // Linear adder reduction; CHUNK is small, so the chain stays short.
  always_comb begin
    o_count = '0;
    for (int i = 0; i < CHUNK; i++) begin
      o_count = o_count + CCW'(i_bits[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/popcount_seq.sv
`default_nettype none
// ============================================================================
//  Module  : popcount_seq
//  Purpose : Multi-cycle population counter. A word is accepted in IDLE,
//            counted CHUNK bits per clock in COUNT, and the result is held
//            in DONE until the consumer takes it. Counts ones (in_mode=0)
//            or zeros (in_mode=1); parity is the count LSB.
//  Ports   : clk, rst_n (sync, active-low)
//            in_valid / in_ready / in_data[WIDTH] / in_mode   - word input
//            out_valid / out_ready / out_count[CW] / out_parity - result
//            busy - high while a word is being counted or held
//  Revision: 1.0 - initial release
// ============================================================================
module popcount_seq
  import popcount_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [cnt_w(WIDTH)-1:0]  out_count,
  output logic                     out_parity,
  output logic                     busy
);

  localparam int NBEATS = WIDTH / CHUNK;
  localparam int CW     = cnt_w(WIDTH);
  localparam int CCW    = cnt_w(CHUNK);
  localparam int BW     = cnt_w(NBEATS);

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("popcount_seq: CHUNK must be in 1..WIDTH and divide WIDTH");
  end

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_shift;
  logic [WIDTH-1:0]   w_shift_nx;
  logic               r_mode;
  logic [CW-1:0]      r_acc;
  logic [BW-1:0]      r_beat;
  logic [CHUNK-1:0]   w_chunk;
  logic [CCW-1:0]     w_chunk_cnt;
  logic               w_accept;
  logic               w_last;

  // Zero mode inverts the slice so the same ones counter yields zeros.
  assign w_chunk = r_shift[CHUNK-1:0] ^ {CHUNK{r_mode}};

  chunk_popcount #(.CHUNK(CHUNK)) u_chunk (
    .i_bits  (w_chunk),
    .o_count (w_chunk_cnt)
  );

  // With a single beat the whole word is consumed at once, so there is
  // nothing left to shift down.
  if (NBEATS == 1) begin : g_shift_one
    assign w_shift_nx = '0;
  end else begin : g_shift_multi
    assign w_shift_nx = {{CHUNK{1'b0}}, r_shift[WIDTH-1:CHUNK]};
  end

  assign w_last = (r_beat == BW'(NBEATS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and state-decoded handshake outputs
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = COUNT;
        end
      end
      COUNT: begin
        busy = 1'b1;
        if (w_last) begin
          w_next = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Datapath: load on accept, accumulate one chunk per COUNT cycle,
  // hold everything in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_mode  <= 1'b0;
      r_acc   <= '0;
      r_beat  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift <= in_data;
            r_mode  <= in_mode;
            r_acc   <= '0;
            r_beat  <= '0;
          end
        end
        COUNT: begin
          r_acc   <= r_acc + CW'(w_chunk_cnt);
          r_shift <= w_shift_nx;
          r_beat  <= r_beat + BW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign out_count  = r_acc;
  assign out_parity = r_acc[0];

endmodule
`default_nettype wire

// File: tb/tb_popcount_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module  : tb_popcount_seq
//  Purpose : Self-checking bench for popcount_seq (16/4 and 8/8 instances).
//  Revision: 1.0 - initial release
// ============================================================================
module tb_popcount_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  // 16-bit, 4-bit chunk instance
  logic        in_valid, in_ready, in_mode;
  logic        out_valid, out_ready, out_parity, busy;
  logic [15:0] in_data;
  logic [4:0]  out_count;

  // 8-bit, single-beat instance
  logic        s_in_valid, s_in_ready, s_in_mode;
  logic        s_out_valid, s_out_ready, s_out_parity, s_busy;
  logic [7:0]  s_in_data;
  logic [3:0]  s_out_count;

  popcount_seq #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_count  (out_count),
    .out_parity (out_parity),
    .busy       (busy)
  );

  popcount_seq #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (s_in_valid),
    .in_ready   (s_in_ready),
    .in_data    (s_in_data),
    .in_mode    (s_in_mode),
    .out_valid  (s_out_valid),
    .out_ready  (s_out_ready),
    .out_count  (s_out_count),
    .out_parity (s_out_parity),
    .busy       (s_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] data;
    logic        mode;
    int          hold;
    int          exp;
  } vec_t;

  vec_t vecs[9];

  // Sends one word and follows it through COUNT and DONE. Called at a
  // negedge with the DUT in IDLE; returns at a negedge back in IDLE.
  task automatic do_word(input logic [15:0] d, input logic m, input int hold,
                         input int exp, input string tag);
    int wait_c;
    int lat;
    in_data   = d;
    in_mode   = m;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    wait_c = 0;
    while (!in_ready && wait_c < 50) begin
      @(negedge clk);
      wait_c++;
    end
    check({tag, " in_ready before accept"}, 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    in_mode  = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      check({tag, " in_ready low in COUNT"}, 32'(in_ready), 0);
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, 4);
    check({tag, " out_count"}, 32'(out_count), exp);
    check({tag, " out_parity"}, 32'(out_parity), exp & 1);
    check({tag, " busy in DONE"}, 32'(busy), 1);
    check({tag, " in_ready low in DONE"}, 32'(in_ready), 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " held out_valid"}, 32'(out_valid), 1);
      check({tag, " held out_count"}, 32'(out_count), exp);
      check({tag, " held in_ready"}, 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, " in_ready after release"}, 32'(in_ready), 1);
    check({tag, " out_valid after release"}, 32'(out_valid), 0);
    check({tag, " busy after release"}, 32'(busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_q[$];
    int sent, got, cyc, e;

    vecs[0] = '{16'hFFFF, 1'b0, 0, 16};
    vecs[1] = '{16'h8001, 1'b0, 0, 2};
    vecs[2] = '{16'h00F0, 1'b1, 0, 12};
    vecs[3] = '{16'h0007, 1'b0, 5, 3};
    vecs[4] = '{16'h0000, 1'b0, 0, 0};
    vecs[5] = '{16'h0000, 1'b1, 0, 16};
    vecs[6] = '{16'hA5A5, 1'b0, 2, 8};
    vecs[7] = '{16'h1234, 1'b1, 0, 11};
    vecs[8] = '{16'hFFFF, 1'b1, 1, 0};

    rst_n      = 1'b0;
    in_valid   = 1'b0; in_data   = 16'hDEAD; in_mode   = 1'b1; out_ready   = 1'b0;
    s_in_valid = 1'b0; s_in_data = 8'h00;    s_in_mode = 1'b0; s_out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("reset in_ready", 32'(in_ready), 1);
    check("reset out_valid", 32'(out_valid), 0);
    check("reset out_count", 32'(out_count), 0);
    check("reset out_parity", 32'(out_parity), 0);
    check("reset busy", 32'(busy), 0);
    check("reset8 in_ready", 32'(s_in_ready), 1);
    check("reset8 out_count", 32'(s_out_count), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // in_valid low: must stay idle whatever in_data shows
    in_data = 16'hFFFF;
    repeat (3) @(negedge clk);
    check("idle without in_valid busy", 32'(busy), 0);

    // Single-beat instance: COUNT lasts exactly one cycle
    s_in_data = 8'hA5; s_in_mode = 1'b1; s_in_valid = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0; s_in_data = 8'hFF;
    check("w8 busy in COUNT", 32'(s_busy), 1);
    check("w8 out_valid in COUNT", 32'(s_out_valid), 0);
    @(negedge clk);
    check("w8 out_valid", 32'(s_out_valid), 1);
    check("w8 A5 zeros", 32'(s_out_count), 4);
    check("w8 parity", 32'(s_out_parity), 0);
    @(negedge clk);
    check("w8 back to idle", 32'(s_in_ready), 1);
    s_in_data = 8'h80; s_in_mode = 1'b0; s_in_valid = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0;
    @(negedge clk);
    check("w8 80 ones", 32'(s_out_count), 1);
    check("w8 80 parity", 32'(s_out_parity), 1);
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 9; i++) begin
      do_word(vecs[i].data, vecs[i].mode, vecs[i].hold, vecs[i].exp,
              $sformatf("vec%0d", i));
    end

    // Reset mid-COUNT at beat 2
    in_data = 16'hFFFF; in_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midcount busy before reset", 32'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset in_ready", 32'(in_ready), 1);
    check("midreset out_valid", 32'(out_valid), 0);
    check("midreset out_count", 32'(out_count), 0);
    check("midreset busy", 32'(busy), 0);
    repeat (6) @(negedge clk);
    check("midreset no stale result", 32'(out_valid), 0);
    do_word(16'h0F0F, 1'b0, 0, 8, "post-reset");

    // Random sweep with random in_valid / out_ready
    sent = 0; got = 0; cyc = 0;
    while (got < 1000 && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      in_valid  = (sent < 1000) && ($urandom_range(0, 9) < 7);
      in_data   = 16'($urandom);
      in_mode   = 1'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      if (in_valid && in_ready) begin
        exp_q.push_back(in_mode ? 16 - $countones(in_data) : $countones(in_data));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rand output with nothing sent", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rand out_count", 32'(out_count), e);
          check("rand out_parity", 32'(out_parity), e & 1);
        end
        got++;
      end
    end
    in_valid = 1'b0;
    check("rand words received", got, 1000);
    check("rand words sent", sent, 1000);
    check("rand nothing left over", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
